bcd_arb: RTL and testbench

- Round-robin arbiter/sequencer sharing one iterative binary-to-BCD encoder (go/done interface, LEN-bit binary in, DIGITS-digit BCD out, sticky ovfl) between NUM_REQ requesters.
- Accepts one request at a time over per-requester valid/ready. Pulses the encoder's go, waits for done, then returns bcd/ovfl tagged with the requester id over a valid/ready response channel.
- Sits between client blocks (display drivers, loggers) and the single shared encoder instance.

---
 rtl/bcd_arb_pkg.sv | 20 ++
 rtl/bcd_arb_rr_pick.sv | 33 +++
 rtl/bcd_arb.sv | 132 +++++++++++++
 tb/tb_bcd_arb.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_arb_pkg.sv
// bcd_pkg: shared types and helpers for the bcd_arb encoder sequencer.
package bcd_pkg;

   // Sequencer states.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GO   = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } arb_state_e;

   // Watchdog budget is WDOG_MULT*LEN cycles in S_WAIT.
   localparam int WDOG_MULT = 4;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bcd_arb_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches req starting at ptr,
// wrapping from N-1 to 0, and returns the first set bit as one-hot and index.
module rr_pick
   import bcd_pkg::*;
#(
   parameter int N   = 3,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] id,
   output logic           any
);

   // First valid requester at or after ptr wins.
   always_comb begin
      int idx;
      grant = '0;
      id    = '0;
      any   = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!any && req[idx]) begin
            grant[idx] = 1'b1;
            id         = IDW'(idx);
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_arb.sv
// bcd_arb: round-robin sequencer sharing one iterative binary-to-BCD encoder
// among NUM_REQ requesters. One job at a time: grant, pulse go, wait for done,
// return the result tagged with the requester id.
// Optional watchdog on the done wait: define BCD_ARB_WDOG_EN.
module bcd_arb
   import bcd_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int LEN     = 4,
   parameter int DIGITS  = 2,
   localparam int IDW    = id_width(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*LEN-1:0]  req_bin,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    enc_go,
   output logic [LEN-1:0]          enc_bin,
   input  logic                    enc_done,
   input  logic [4*DIGITS-1:0]     enc_bcd,
   input  logic                    enc_ovfl,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [IDW-1:0]          resp_id,
   output logic [4*DIGITS-1:0]     resp_bcd,
   output logic                    resp_ovfl,
   output logic                    busy
`ifdef BCD_ARB_WDOG_EN
   ,
   output logic                    wdog_err
`endif
);

   arb_state_e         state;
   logic [IDW-1:0]     ptr;
   logic [IDW-1:0]     gid;
   logic [NUM_REQ-1:0] pick_grant;
   logic [IDW-1:0]     pick_id;
   logic               pick_any;

`ifdef BCD_ARB_WDOG_EN
   localparam int WDOG_LIMIT = WDOG_MULT * LEN;
   localparam int WDW        = $clog2(WDOG_LIMIT + 1) + 1;
   logic [WDW-1:0] wdog_cnt;
`endif

   rr_pick #(
      .N   (NUM_REQ),
      .IDW (IDW)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (pick_grant),
      .id    (pick_id),
      .any   (pick_any)
   );

   // Grant is offered only while idle, and never while reset is asserted.
   assign req_ready = (state == S_IDLE && rst_n) ? pick_grant : '0;

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ptr        <= '0;
         gid        <= '0;
         enc_go     <= 1'b0;
         enc_bin    <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_bcd   <= '0;
         resp_ovfl  <= 1'b0;
         busy       <= 1'b0;
`ifdef BCD_ARB_WDOG_EN
         wdog_cnt   <= '0;
         wdog_err   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (|(req_valid & req_ready)) begin
                  gid     <= pick_id;
                  enc_bin <= req_bin[int'(pick_id)*LEN +: LEN];
                  enc_go  <= 1'b1;
                  busy    <= 1'b1;
                  state   <= S_GO;
               end
            end
            S_GO: begin
               // done may still show the previous job here, so it is not looked at
               enc_go <= 1'b0;
               state  <= S_WAIT;
`ifdef BCD_ARB_WDOG_EN
               wdog_cnt <= '0;
`endif
            end
            S_WAIT: begin
               if (enc_done) begin
                  resp_bcd   <= enc_bcd;
                  resp_ovfl  <= enc_ovfl;
                  resp_id    <= gid;
                  resp_valid <= 1'b1;
                  state      <= S_RESP;
               end
`ifdef BCD_ARB_WDOG_EN
               else if (wdog_cnt == WDW'(WDOG_LIMIT)) begin
                  resp_bcd   <= '0;
                  resp_ovfl  <= 1'b1;
                  resp_id    <= gid;
                  resp_valid <= 1'b1;
                  wdog_err   <= 1'b1;
                  state      <= S_RESP;
               end else begin
                  wdog_cnt <= wdog_cnt + 1'b1;
               end
`endif
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  ptr        <= (int'(gid) == NUM_REQ - 1) ? '0 : gid + 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_arb.sv
// tb_bcd_arb: directed bench for bcd_arb with a behavioural encoder model.
// Second instance (LEN=8) covers the overflow path. Define BCD_ARB_WDOG_EN
// to include the watchdog checks.
module tb_bcd_arb;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // DUT A: NUM_REQ=3, LEN=4, DIGITS=2
   logic [2:0]  req_valid;
   logic [11:0] req_bin;
   logic [2:0]  req_ready;
   logic        enc_go;
   logic [3:0]  enc_bin;
   logic        enc_done;
   logic [7:0]  enc_bcd;
   logic        enc_ovfl;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_id;
   logic [7:0]  resp_bcd;
   logic        resp_ovfl;
   logic        busy;
`ifdef BCD_ARB_WDOG_EN
   logic        wdog_err;
   logic        b_wdog_err;
`endif

   // DUT B: NUM_REQ=2, LEN=8, DIGITS=2
   logic [1:0]  b_req_valid;
   logic [15:0] b_req_bin;
   logic [1:0]  b_req_ready;
   logic        b_enc_go;
   logic [7:0]  b_enc_bin;
   logic        b_enc_done;
   logic [7:0]  b_enc_bcd;
   logic        b_enc_ovfl;
   logic        b_resp_valid;
   logic        b_resp_ready;
   logic [0:0]  b_resp_id;
   logic [7:0]  b_resp_bcd;
   logic        b_resp_ovfl;
   logic        b_busy;

   logic hold_done;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   multi_hot = 0;
   int   go_cnt = 0;
   int   go_double = 0;
   logic go_prev = 1'b0;
   int   a_cnt, a_val, b_cnt, b_val;

   bcd_arb #(.NUM_REQ(3), .LEN(4), .DIGITS(2)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_bin(req_bin), .req_ready(req_ready),
      .enc_go(enc_go), .enc_bin(enc_bin), .enc_done(enc_done),
      .enc_bcd(enc_bcd), .enc_ovfl(enc_ovfl),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_bcd(resp_bcd), .resp_ovfl(resp_ovfl), .busy(busy)
`ifdef BCD_ARB_WDOG_EN
      , .wdog_err(wdog_err)
`endif
   );

   bcd_arb #(.NUM_REQ(2), .LEN(8), .DIGITS(2)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_req_valid), .req_bin(b_req_bin), .req_ready(b_req_ready),
      .enc_go(b_enc_go), .enc_bin(b_enc_bin), .enc_done(b_enc_done),
      .enc_bcd(b_enc_bcd), .enc_ovfl(b_enc_ovfl),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_id(b_resp_id),
      .resp_bcd(b_resp_bcd), .resp_ovfl(b_resp_ovfl), .busy(b_busy)
`ifdef BCD_ARB_WDOG_EN
      , .wdog_err(b_wdog_err)
`endif
   );

   // Two-digit encoder result: {ovfl, tens, units}.
   function automatic logic [8:0] enc_ref(input int v);
      int m;
      m = v % 100;
      return {(v >= 100), 4'(m / 10), 4'(m % 10)};
   endfunction

   // Encoder model A: done drops after go, rises 2*LEN-1 cycles later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_done <= 1'b0; a_cnt <= 0; a_val <= 0; enc_bcd <= '0; enc_ovfl <= 1'b0;
      end else if (enc_go) begin
         enc_done <= 1'b0; a_cnt <= 7; a_val <= int'(enc_bin);
      end else if (a_cnt > 0) begin
         a_cnt <= a_cnt - 1;
         if (a_cnt == 1 && !hold_done) begin
            enc_done <= 1'b1;
            {enc_ovfl, enc_bcd} <= enc_ref(a_val);
         end
      end
   end

   // Encoder model B (LEN=8).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_enc_done <= 1'b0; b_cnt <= 0; b_val <= 0; b_enc_bcd <= '0; b_enc_ovfl <= 1'b0;
      end else if (b_enc_go) begin
         b_enc_done <= 1'b0; b_cnt <= 15; b_val <= int'(b_enc_bin);
      end else if (b_cnt > 0) begin
         b_cnt <= b_cnt - 1;
         if (b_cnt == 1) begin
            b_enc_done <= 1'b1;
            {b_enc_ovfl, b_enc_bcd} <= enc_ref(b_val);
         end
      end
   end

   // Monitor grant one-hotness and go pulse width on DUT A.
   always @(negedge clk) begin
      if ($countones(req_ready) > 1) multi_hot++;
      if (enc_go) go_cnt++;
      if (enc_go && go_prev) go_double++;
      go_prev = enc_go;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bounded wait for resp_valid on DUT A (which=0) or DUT B (which=1).
   task automatic wait_resp(input string tag, input bit which);
      int n;
      n = 0;
      while (!(which ? b_resp_valid : resp_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_resp_valid"}, which ? b_resp_valid : resp_valid, 1);
   endtask

   logic [7:0] exp_bcd [3];
   int go0, viol, rr_viol, seen;

   initial begin
      rst_n = 1'b0; req_valid = '0; req_bin = '0; resp_ready = 1'b0; hold_done = 1'b0;
      b_req_valid = '0; b_req_bin = '0; b_resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_enc_go", enc_go, 0);
      check("rst_enc_bin", enc_bin, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_bcd", resp_bcd, 0);
      check("rst_resp_ovfl", resp_ovfl, 0);
      check("rst_busy", busy, 0);
`ifdef BCD_ARB_WDOG_EN
      check("rst_wdog_err", wdog_err, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Contention: all three valid, served 0,1,2.
      exp_bcd = '{8'h09, 8'h12, 8'h03};
      req_bin = {4'h3, 4'hC, 4'h9};
      req_valid = 3'b111;
      resp_ready = 1'b1;
      #1 check("cont_grant0", req_ready, 3'b001);
      for (int k = 0; k < 3; k++) begin
         wait_resp("cont", 0);
         check("cont_id", resp_id, k);
         check("cont_bcd", resp_bcd, exp_bcd[k]);
         req_valid[k] = 1'b0;
         @(negedge clk);
         check("cont_accept", resp_valid, 0);
      end
      check("cont_multi_hot", multi_hot, 0);
      check("cont_go_cnt", go_cnt, 3);
      check("cont_go_width", go_double, 0);

      // Single request from requester 1 with 0xF.
      resp_ready = 1'b0;
      req_bin[7:4] = 4'hF;
      req_valid = 3'b010;
      #1 check("single_grant", req_ready, 3'b010);
      @(negedge clk);
      check("single_go", enc_go, 1);
      check("single_enc_bin", enc_bin, 4'hF);
      check("single_busy", busy, 1);
      check("single_ready_busy", req_ready, 0);
      req_valid = '0;
      @(negedge clk);
      check("single_go_drop", enc_go, 0);
      wait_resp("single", 0);
      check("single_bcd", resp_bcd, 8'h15);
      check("single_id", resp_id, 1);
      check("single_ovfl", resp_ovfl, 0);
      resp_ready = 1'b1;
      @(negedge clk);
      check("single_accept", resp_valid, 0);
      check("single_idle", busy, 0);

      // Fairness wrap: pointer now 2, requesters 0 and 2 valid.
      req_bin = {4'hA, 4'h0, 4'h7};
      req_valid = 3'b101;
      #1 check("wrap_grant", req_ready, 3'b100);
      wait_resp("wrap1", 0);
      check("wrap1_id", resp_id, 2);
      check("wrap1_bcd", resp_bcd, 8'h10);
      req_valid[2] = 1'b0;
      @(negedge clk);
      wait_resp("wrap2", 0);
      check("wrap2_id", resp_id, 0);
      check("wrap2_bcd", resp_bcd, 8'h07);
      req_valid[0] = 1'b0;
      @(negedge clk);

      // Backpressure: hold the result 10 cycles with other requesters pending.
      resp_ready = 1'b0;
      req_bin = {4'h5, 4'h1, 4'h1};
      req_valid = 3'b100;
      wait_resp("bp", 0);
      req_valid = 3'b111;
      go0 = go_cnt; viol = 0; rr_viol = 0;
      repeat (10) begin
         @(negedge clk);
         if (resp_bcd !== 8'h05 || resp_id !== 2'd2 || resp_valid !== 1'b1 || resp_ovfl !== 1'b0) viol++;
         if (req_ready !== 3'b000) rr_viol++;
      end
      check("bp_stable", viol, 0);
      check("bp_no_grant", rr_viol, 0);
      check("bp_no_go", go_cnt - go0, 0);
      check("bp_bcd", resp_bcd, 8'h05);
      req_valid = '0;
      resp_ready = 1'b1;
      @(negedge clk);
      check("bp_accept", resp_valid, 0);
      resp_ready = 1'b0;

      // Reset while waiting for done: job abandoned, no response.
      req_bin[3:0] = 4'h3;
      req_valid = 3'b001;
      repeat (3) @(negedge clk);
      req_valid = '0;
      check("rstw_busy_before", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rstw_busy", busy, 0);
      check("rstw_enc_bin", enc_bin, 0);
      check("rstw_resp_valid", resp_valid, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (resp_valid) seen = 1;
      end
      check("rstw_no_resp", seen, 0);
      req_bin[7:4] = 4'h8;
      req_valid = 3'b010;
      @(negedge clk);
      req_valid = '0;
      wait_resp("rstw_next", 0);
      check("rstw_next_id", resp_id, 1);
      check("rstw_next_bcd", resp_bcd, 8'h08);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;

`ifdef BCD_ARB_WDOG_EN
      // Watchdog: done never arrives.
      hold_done = 1'b1;
      req_bin[3:0] = 4'h2;
      req_valid = 3'b001;
      @(negedge clk);
      req_valid = '0;
      wait_resp("wdog", 0);
      check("wdog_err", wdog_err, 1);
      check("wdog_ovfl", resp_ovfl, 1);
      check("wdog_bcd", resp_bcd, 0);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("wdog_sticky", wdog_err, 1);
      hold_done = 1'b0;
`endif

      // Overflow on the LEN=8 instance.
      b_req_bin = {8'd99, 8'd200};
      b_req_valid = 2'b01;
      @(negedge clk);
      b_req_valid = '0;
      wait_resp("ovf", 1);
      check("ovf_flag", b_resp_ovfl, 1);
      check("ovf_bcd", b_resp_bcd, 8'h00);
      check("ovf_id", b_resp_id, 0);
      b_resp_ready = 1'b1;
      @(negedge clk);
      b_resp_ready = 1'b0;
      b_req_valid = 2'b10;
      @(negedge clk);
      b_req_valid = '0;
      wait_resp("b99", 1);
      check("b99_flag", b_resp_ovfl, 0);
      check("b99_bcd", b_resp_bcd, 8'h99);
      check("b99_id", b_resp_id, 1);
      b_resp_ready = 1'b1;
      @(negedge clk);
      b_resp_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
